// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, word address to async instruction memory, IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetch_count / bubble_count performance counters.
module fetch_stage #(
  parameter int unsigned          PC_WIDTH   = 32,
  parameter int unsigned          ADDR_WIDTH = 6,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]   if_id_pc4,
  output logic                  if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           bubble_count
`endif
);

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] target_aligned;
  logic                unused_target_bits;

  assign pc_plus4       = pc + PC_WIDTH'(4);
  assign target_aligned = {redirect_target[PC_WIDTH-1:2], 2'b00};
  assign unused_target_bits = ^redirect_target[1:0];

  // PC bits above the memory word range are ignored, so high addresses alias.
  assign imem_addr = pc[ADDR_WIDTH+1:2];

  // Priority: reset > redirect (flushes IF/ID, beats stall) > stall > advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= target_aligned;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= pc_plus4;
      if_id_instr <= imem_data;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else if (redirect || stall) begin
      bubble_count <= bubble_count + 32'd1;
    end else begin
      fetch_count  <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: spec-level model checked every cycle plus literal pins.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  logic [31:0] mem [64];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Spec-level model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_fetch;
  logic [31:0] m_bubble;
  bit          m_known = 1'b0;

  fetch_stage #(
    .PC_WIDTH   (32),
    .ADDR_WIDTH (6),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .pc              (pc),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .bubble_count    (bubble_count)
`endif
  );

  assign imem_data = mem[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: instruction fetched is the memory word at (pc / 4) mod 64.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_fetch = 32'h0; m_bubble = 32'h0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (redirect) begin
        m_pc = (redirect_target / 4) * 4;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_bubble = m_bubble + 1;
      end else if (stall) begin
        m_bubble = m_bubble + 1;
      end else begin
        m_instr = mem[(m_pc / 4) % 64];
        m_pc = m_pc + 4;
        m_pc4 = m_pc;
        m_valid = 1'b1;
        m_fetch = m_fetch + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", 32'(imem_addr), (m_pc / 4) % 64);
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_pc4", if_id_pc4, m_pc4);
      chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fetch);
      chk("bubble_count", bubble_count, m_bubble);
`endif
    end
  end

  task automatic step(input bit rst_n, input bit st, input bit rd, input logic [31:0] tgt);
    reset_n = rst_n;
    stall = st;
    redirect = rd;
    redirect_target = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int unsigned k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("lit_reset_pc", pc, 32'h0);
    chk("lit_reset_valid", 32'(if_id_valid), 32'h0);
    chk("lit_reset_instr", if_id_instr, 32'h0);

    // Straight-line fetch
    step(1, 0, 0, 0);
    chk("lit_sl_pc", pc, 32'h4);
    chk("lit_sl_instr0", if_id_instr, 32'h1000_0000);
    chk("lit_sl_pc4_0", if_id_pc4, 32'h4);
    step(1, 0, 0, 0);
    chk("lit_sl_instr1", if_id_instr, 32'h1000_0001);
    chk("lit_sl_pc4_1", if_id_pc4, 32'h8);

    // Stall hold at pc 0x8
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("lit_stall_pc", pc, 32'h8);
    chk("lit_stall_instr", if_id_instr, 32'h1000_0001);
    chk("lit_stall_pc4", if_id_pc4, 32'h8);
    step(1, 0, 0, 0);
    chk("lit_unstall_instr", if_id_instr, 32'h1000_0002);
    chk("lit_unstall_pc", pc, 32'hC);

    // Redirect flush to 0x23 -> 0x20
    step(1, 0, 1, 32'h23);
    chk("lit_redir_pc", pc, 32'h20);
    chk("lit_redir_valid", 32'(if_id_valid), 32'h0);
    chk("lit_redir_instr", if_id_instr, 32'h0);
    step(1, 0, 0, 0);
    chk("lit_redir_next_instr", if_id_instr, 32'h1000_0008);
    chk("lit_redir_next_pc4", if_id_pc4, 32'h24);

    // Redirect wins over stall
    step(1, 1, 1, 32'h40);
    chk("lit_rs_pc", pc, 32'h40);
    chk("lit_rs_valid", 32'(if_id_valid), 32'h0);
    step(1, 0, 0, 0);

    // Wrap and alias
    step(1, 0, 1, 32'hFFFF_FFFC);
    chk("lit_wrap_addr", 32'(imem_addr), 32'd63);
    step(1, 0, 0, 0);
    chk("lit_wrap_instr", if_id_instr, 32'h1000_003F);
    chk("lit_wrap_pc", pc, 32'h0);
    step(1, 0, 1, 32'h100);
    chk("lit_alias_addr", 32'(imem_addr), 32'd0);
    step(1, 0, 0, 0);
    chk("lit_alias_pc4", if_id_pc4, 32'h104);

    // Back-to-back redirects
    step(1, 0, 1, 32'h10);
    step(1, 0, 1, 32'h31);
    chk("lit_b2b_pc", pc, 32'h30);
    chk("lit_b2b_valid", 32'(if_id_valid), 32'h0);
    step(1, 0, 0, 0);
    chk("lit_b2b_instr", if_id_instr, 32'h1000_000C);

    // Reset during stall at pc 0x14
    step(1, 0, 1, 32'h10);
    step(1, 0, 0, 0);
    chk("lit_pre_rst_pc", pc, 32'h14);
    step(0, 1, 0, 0);
    chk("lit_midrst_pc", pc, 32'h0);
    chk("lit_midrst_valid", 32'(if_id_valid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("lit_midrst_fcnt", fetch_count, 32'h0);
    chk("lit_midrst_bcnt", bubble_count, 32'h0);
`endif
    step(1, 0, 0, 0);
    chk("lit_postrst_instr", if_id_instr, 32'h1000_0000);

    // Short mixed directed tail checked by the model
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h2E);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
